// File: rtl/ppu_vram_port_pkg.sv
// Shared definitions for the PPU video-memory port: CPU register selects,
// port FSM states and address increment steps.
package ppu_vram_port_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam logic [13:0] INC_1  = 14'd1;
  localparam logic [13:0] INC_32 = 14'd32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

endpackage

// File: rtl/ppu_vram_port.sv
// CPU-side access port into PPU video memory. The renderer always has
// priority on the memory bus; CPU DATA accesses are parked in a one-deep
// pending slot and performed in the first free bus cycle.
// Optional feature: define PPU_RDBUF_EN for the buffered (one-read-behind)
// DATA read behaviour; when undefined, DATA reads return the fetched byte.
module ppu_vram_port
  import ppu_vram_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_sel,
  input  logic        cpu_rnw,
  input  logic [2:0]  cpu_ra,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  input  logic        vblank,
  input  logic        render_active,
  input  logic [13:0] render_a,
  output logic [13:0] vram_a,
  output logic [7:0]  vram_dout,
  output logic        vram_wr,
  input  logic [7:0]  vram_din
);

  state_t      state, state_next;
  logic [13:0] addr;
  logic        w;
  logic        inc32;
  logic [13:0] inc;
  logic [13:0] pend_addr;
  logic [7:0]  pend_data;
  logic        pend_rnw;
  logic [7:0]  rdbuf;
  logic [7:0]  cpu_dout_q;
  logic        reg_wr;
  logic        data_accept;

  assign inc         = inc32 ? INC_32 : INC_1;
  assign reg_wr      = cpu_sel && !cpu_rnw;
  assign data_accept = cpu_sel && (cpu_ra == REG_DATA) && (state == ST_IDLE);
  assign cpu_rdy     = (state == ST_IDLE);
  assign cpu_dout    = cpu_dout_q;
  assign vram_dout   = pend_data;

  // Renderer owns the address bus whenever active; otherwise the pending slot drives it
  always_comb begin
    vram_a  = pend_addr;
    vram_wr = 1'b0;
    if (render_active) begin
      vram_a = render_a;
    end else if (state == ST_ACCESS && !pend_rnw) begin
      vram_wr = 1'b1;
    end
  end

  // Next-state logic: go straight to ACCESS when the bus is free at acceptance
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (data_accept) begin
          state_next = render_active ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (!render_active) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (render_active) begin
          state_next = ST_WAIT;
        end else if (pend_rnw) begin
          state_next = ST_FILL;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FILL: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // CPU-visible registers: increment mode, address with its write toggle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr  <= '0;
      w     <= 1'b0;
      inc32 <= 1'b0;
    end else begin
      if (reg_wr && cpu_ra == REG_CTRL) begin
        inc32 <= cpu_din[2];
      end
      if (reg_wr && cpu_ra == REG_ADDR) begin
        if (!w) begin
          addr[13:8] <= cpu_din[5:0];
        end else begin
          addr[7:0] <= cpu_din;
        end
        w <= ~w;
      end
      if (cpu_sel && cpu_rnw && cpu_ra == REG_STATUS) begin
        w <= 1'b0;
      end
      if (data_accept) begin
        addr <= addr + inc;
      end
    end
  end

  // Pending slot captures the address and write data of an accepted DATA access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_addr <= '0;
      pend_data <= '0;
      pend_rnw  <= 1'b0;
    end else if (data_accept) begin
      pend_addr <= addr;
      pend_rnw  <= cpu_rnw;
      if (!cpu_rnw) begin
        pend_data <= cpu_din;
      end
    end
  end

  // Read path: FILL captures the fetched byte, CPU reads update the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdbuf      <= '0;
      cpu_dout_q <= '0;
    end else begin
      if (state == ST_FILL) begin
        rdbuf <= vram_din;
`ifndef PPU_RDBUF_EN
        cpu_dout_q <= vram_din;
`endif
      end
      if (cpu_sel && cpu_rnw) begin
        case (cpu_ra)
          REG_STATUS: begin
            cpu_dout_q <= {vblank, 7'b0};
          end
          REG_DATA: begin
`ifdef PPU_RDBUF_EN
            if (state == ST_IDLE) begin
              cpu_dout_q <= rdbuf;
            end
`endif
          end
          default: begin
            cpu_dout_q <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule
